bcd_to_bin: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the score path's binary-to-BCD stage. It accepts a packed BCD value in the same width the score encoder produces and recovers the W-bit binary value by reverse double dabble: shift right one bit per cycle, then subtract 3 from every digit ≥ 8. It is used wherever a BCD-held value (e.g., a stored or displayed score) must re-enter binary arithmetic, and it flags invalid digits and out-of-range values.

---
 rtl/bcd_to_bin_if.sv | 40 ++++
 rtl/bcd_to_bin.sv | 103 ++++++++++
 tb/tb_bcd_to_bin.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_bin_if
// Brief   : Request/result bundle between a client and the BCD-to-binary converter.
// Revision: 1.0
// ============================================================================
interface bcd_to_bin_if #(
  parameter int W = 16
);
  localparam int BW = W + (W - 4) / 3;

  logic          start;
  logic [BW-1:0] bcd;
  logic          busy;
  logic          done;
  logic [W-1:0]  bin;
  logic          inv;
  logic          ovf;

  modport master (
    output start,
    output bcd,
    input  busy,
    input  done,
    input  bin,
    input  inv,
    input  ovf
  );

  modport slave (
    input  start,
    input  bcd,
    output busy,
    output done,
    output bin,
    output inv,
    output ovf
  );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module  : bcd_to_bin
// Brief   : Sequential BCD-to-binary converter (reverse double dabble, W cycles).
// Revision: 1.0
// ============================================================================
module bcd_to_bin #(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        rst,
  bcd_to_bin_if.slave bus
);
  localparam int BW = W + (W - 4) / 3;
  localparam int ND = (BW + 3) / 4;
  localparam int DW = 4 * ND;
  localparam int CW = $clog2(W + 1);
  localparam int XW = DW + W;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         r_state;
  logic [XW-1:0]  r_work;
  logic [CW-1:0]  r_cnt;
  logic           r_inv_lat;
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_bin;
  logic           r_inv;
  logic           r_ovf;

  logic [DW-1:0]  w_load_bcd;
  logic [ND-1:0]  w_digit_inv;
  logic [XW-1:0]  w_shift;
  logic [XW-1:0]  w_corr;
  logic           w_last;

  // Only a partial top digit gets padded; full digits pass straight through.
  assign w_load_bcd = DW'(bus.bcd);
  assign w_shift    = r_work >> 1;
  assign w_last     = (r_cnt == CW'(W - 1));

  assign w_corr[W-1:0] = w_shift[W-1:0];

  genvar gi;
  for (gi = 0; gi < ND; gi++) begin : g_digit
    assign w_digit_inv[gi] = (w_load_bcd[4*gi +: 4] > 4'd9);
    assign w_corr[W+4*gi +: 4] = (w_shift[W+4*gi +: 4] >= 4'd8)
                               ? (w_shift[W+4*gi +: 4] - 4'd3)
                               : w_shift[W+4*gi +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_inv_lat <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bin     <= '0;
      r_inv     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work    <= {w_load_bcd, {W{1'b0}}};
            r_cnt     <= '0;
            r_inv_lat <= |w_digit_inv;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_corr;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            // Any BCD residue after W shifts means the value did not fit in W bits.
            r_bin   <= r_inv_lat ? '0 : w_corr[W-1:0];
            r_ovf   <= ~r_inv_lat & (|w_corr[XW-1:W]);
            r_inv   <= r_inv_lat;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bin  = r_bin;
  assign bus.inv  = r_inv;
  assign bus.ovf  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_to_bin
// Brief   : Directed + random scoreboard bench for bcd_to_bin (W=16).
// Revision: 1.0
// ============================================================================
module tb_bcd_to_bin;
  localparam int W  = 16;
  localparam int BW = 20;

  typedef struct {
    logic [W-1:0] bin;
    logic         inv;
    logic         ovf;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  bcd_to_bin_if #(.W(W)) bus ();

  bcd_to_bin #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Result checker: every done pulse must retire exactly one expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      n_vec++;
      assert (sbq.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_done: observed done with empty scoreboard, required no done");
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_vec++;
        assert ({bus.bin, bus.inv, bus.ovf} === {e.bin, e.inv, e.ovf}) else begin
          n_err++;
          $error("FAIL %s: observed bin=%h inv=%b ovf=%b, required bin=%h inv=%b ovf=%b",
                 e.tag, bus.bin, bus.inv, bus.ovf, e.bin, e.inv, e.ovf);
        end
      end
    end
  end

  task automatic convert(input logic [BW-1:0] v, input logic [W-1:0] eb,
                         input logic ei, input logic eo, input string tag);
    int n;
    int nbusy;
    bit seen;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = v;
    e.bin = eb; e.inv = ei; e.ovf = eo; e.tag = tag;
    sbq.push_back(e);
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n - 1), 32'd16);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd16);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_bin_held"}, 32'(bus.bin), 32'(eb));
  endtask

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] b;
    int t;
    b = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  initial begin
    int   n;
    int   m;
    int   d0;
    bit   seen;
    exp_t e;

    bus.start = 1'b0;
    bus.bcd   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, bus.busy, bus.done, bus.inv, bus.ovf, 1'b0}, 32'd0);
    check("reset_bin", 32'(bus.bin), 32'd0);
    rst = 1'b0;

    convert(20'h12345, 16'h3039, 1'b0, 1'b0, "conv_12345");
    convert(20'h00000, 16'h0000, 1'b0, 1'b0, "conv_zero");
    convert(20'h65535, 16'hFFFF, 1'b0, 1'b0, "conv_65535");
    convert(20'h65536, 16'h0000, 1'b0, 1'b1, "conv_65536");
    convert(20'h99999, 16'h869F, 1'b0, 1'b1, "conv_99999");
    convert(20'h0001A, 16'h0000, 1'b1, 1'b0, "conv_invalid");
    convert(20'h00042, 16'h002A, 1'b0, 1'b0, "conv_after_inv");

    // Start pulses while busy must be ignored.
    d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 20'h12345;
    e.bin = 16'h3039; e.inv = 1'b0; e.ovf = 1'b0; e.tag = "busy_ignore";
    sbq.push_back(e);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (n == 3 || n == 9) begin bus.start = 1'b1; bus.bcd = 20'h99999; end
      if (n == 4 || n == 10) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("busy_ignore_latency", 32'(n - 1), 32'd16);
    repeat (20) @(negedge clk);
    check("busy_ignore_one_done", 32'(n_done - d0), 32'd1);

    // Back-to-back: second start raised during the done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 20'h00042;
    e.bin = 16'h002A; e.inv = 1'b0; e.ovf = 1'b0; e.tag = "b2b_first";
    sbq.push_back(e);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("b2b_first_seen", 32'(seen), 32'd1);
    bus.start = 1'b1;
    bus.bcd   = 20'h00100;
    e.bin = 16'h0064; e.inv = 1'b0; e.ovf = 1'b0; e.tag = "b2b_second";
    sbq.push_back(e);
    m = 0; seen = 1'b0;
    while (!seen && m < 40) begin
      @(negedge clk);
      m++;
      if (m == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("b2b_spacing", 32'(m), 32'd17);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run discards the conversion.
    d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd   = 20'h12345;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
    end
    check("midrun_busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_flags", {27'd0, bus.busy, bus.done, bus.inv, bus.ovf, 1'b0}, 32'd0);
    check("midrun_rst_bin", 32'(bus.bin), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("midrun_no_done", 32'(n_done - d0), 32'd0);
    convert(20'h00100, 16'h0064, 1'b0, 1'b0, "after_rst_100");

    // Random valid values round-tripped through a decimal encoder.
    for (int k = 0; k < 1000; k++) begin
      int v;
      v = int'($urandom_range(0, 99999));
      convert(to_bcd(v), 16'(v), 1'b0, (v > 65535), "random");
    end

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
